// File: rtl/fir_tap_accumulator.sv
// ---------------------------------------------------------------------------
// fir_tap_accumulator
// Sums NUM_TAPS signed products of one input sample into one FIR output. It
// rounds half-up, shifts right arithmetically and saturates the result to
// OUT_WIDTH.
// The tap counter is driven back upstream as tap_idx, so the coefficient mux
// stays aligned with the product arriving here.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   prod_vld   in   prod_data valid this cycle
//   prod_data  in   signed product from the multiplier (SUM_WIDTH)
//   flush      in   synchronous abort of the partial frame; wins over prod_vld
//   tap_idx    out  index of the next expected tap
//   out_data   out  rounded, shifted, saturated sample (OUT_WIDTH, signed)
//   out_vld    out  one-cycle strobe, out_data/out_sat valid
//   out_sat    out  saturation occurred on this sample
// ---------------------------------------------------------------------------
module fir_tap_accumulator #(
    parameter int SUM_WIDTH = 34,
    parameter int NUM_TAPS  = 16,
    parameter int ACC_WIDTH = 38,
    parameter int OUT_WIDTH = 34,
    parameter int OUT_SHIFT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          prod_vld,
    input  logic [SUM_WIDTH-1:0]          prod_data,
    input  logic                          flush,
    output logic [$clog2(NUM_TAPS)-1:0]   tap_idx,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic                          out_vld,
    output logic                          out_sat
);

    localparam int CNT_W = $clog2(NUM_TAPS);
    // Round/shift arithmetic is one bit wider than the accumulator. It is
    // also wide enough to hold the output limits, so the sum never wraps.
    localparam int CW      = (ACC_WIDTH + 1 > OUT_WIDTH + 1) ? ACC_WIDTH + 1 : OUT_WIDTH + 1;
    localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [CW-1:0] RND     = (OUT_SHIFT > 0) ? (CW'(1) << RND_POS) : '0;
    localparam logic signed [CW-1:0] SAT_MAX = {{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN = ~SAT_MAX;

    logic [CNT_W-1:0]            tap_cnt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum_q;
    logic                        pend;

    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic                        last_tap;
    logic                        take;

    logic signed [CW-1:0]        sum_w;
    logic signed [CW-1:0]        rnd_sum;
    logic signed [CW-1:0]        shifted;

    assign prod_ext = {{(ACC_WIDTH-SUM_WIDTH){prod_data[SUM_WIDTH-1]}}, prod_data};
    // Tap 0 restarts the sum, so back-to-back frames need no clearing bubble.
    assign acc_base = (tap_cnt == '0) ? '0 : acc;
    assign acc_sum  = acc_base + prod_ext;
    assign last_tap = (tap_cnt == CNT_W'(NUM_TAPS - 1));
    assign take     = prod_vld && !flush;
    assign tap_idx  = tap_cnt;

    // Stage 1: tap counting and accumulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap_cnt <= '0;
            acc     <= '0;
            sum_q   <= '0;
            pend    <= 1'b0;
        end else begin
            if (flush) begin
                tap_cnt <= '0;
                acc     <= '0;
            end else if (prod_vld) begin
                acc <= acc_sum;
                if (last_tap) begin
                    tap_cnt <= '0;
                    sum_q   <= acc_sum;
                end else begin
                    tap_cnt <= tap_cnt + 1'b1;
                end
            end
            // Stage 2 always consumes pend on the next cycle. Frames are at
            // least NUM_TAPS >= 2 cycles apart, so set and clear never
            // collide. A flush does not touch a pend that is already set.
            pend <= take && last_tap;
        end
    end

    assign sum_w   = {{(CW-ACC_WIDTH){sum_q[ACC_WIDTH-1]}}, sum_q};
    assign rnd_sum = sum_w + RND;
    assign shifted = rnd_sum >>> OUT_SHIFT;

    // Stage 2: round, shift and saturate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data <= '0;
            out_vld  <= 1'b0;
            out_sat  <= 1'b0;
        end else begin
            out_vld <= pend;
            if (pend) begin
                if (shifted > SAT_MAX) begin
                    out_data <= SAT_MAX[OUT_WIDTH-1:0];
                    out_sat  <= 1'b1;
                end else if (shifted < SAT_MIN) begin
                    out_data <= SAT_MIN[OUT_WIDTH-1:0];
                    out_sat  <= 1'b1;
                end else begin
                    out_data <= shifted[OUT_WIDTH-1:0];
                    out_sat  <= 1'b0;
                end
            end
        end
    end

endmodule
